// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Opcodes, FSM states, instruction classes and control-bit indices.
package cu_pkg;

  localparam int OPC_W     = 5;
  localparam int NUM_ALUOP = 13;
  localparam int NUM_DRV   = 9;
  localparam int NUM_LD    = 11;

  localparam logic [OPC_W-1:0] OP_LD   = 5'd0;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OPC_W-1:0] OP_ST   = 5'd2;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd5;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd6;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'd7;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'd8;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'd9;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'd10;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd11;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'd12;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'd13;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'd14;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'd15;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'd16;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd17;
  localparam logic [OPC_W-1:0] OP_BR   = 5'd18;
  localparam logic [OPC_W-1:0] OP_JR   = 5'd19;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'd20;
  localparam logic [OPC_W-1:0] OP_IN   = 5'd21;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'd22;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'd23;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'd24;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'd25;
  localparam logic [OPC_W-1:0] OP_HALT = 5'd26;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4,
    S_T5, S_T6, S_T7, S_HALT, S_WAIT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LD, C_LDI, C_ST, C_MULDIV,
    C_UNARY, C_BR, C_JR, C_JAL, C_IN, C_OUT,
    C_MFHI, C_MFLO, C_NOP, C_HALT
  } cls_e;

  // drv bits, LSB first
  localparam int D_ROUT = 0;
  localparam int D_INP  = 1;
  localparam int D_MDR  = 2;
  localparam int D_PC   = 3;
  localparam int D_ZLO  = 4;
  localparam int D_ZHI  = 5;
  localparam int D_LO   = 6;
  localparam int D_HI   = 7;
  localparam int D_C    = 8;

  localparam int L_OUTP = 0;
  localparam int L_CON  = 1;
  localparam int L_R    = 2;
  localparam int L_MDR  = 3;
  localparam int L_Z    = 4;
  localparam int L_LO   = 5;
  localparam int L_HI   = 6;
  localparam int L_Y    = 7;
  localparam int L_MAR  = 8;
  localparam int L_IR   = 9;
  localparam int L_PC   = 10;

  localparam int A_INCPC = 0;
  localparam int A_NOT   = 1;
  localparam int A_NEG   = 2;
  localparam int A_ROL   = 3;
  localparam int A_ROR   = 4;
  localparam int A_SHL   = 5;
  localparam int A_SHR   = 6;
  localparam int A_DIV   = 7;
  localparam int A_MUL   = 8;
  localparam int A_SUB   = 9;
  localparam int A_ADD   = 10;
  localparam int A_OR    = 11;
  localparam int A_AND   = 12;

  localparam int G_C = 0;
  localparam int G_B = 1;
  localparam int G_A = 2;

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: instruction class plus one-hot ALU operation.
// Undefined opcodes decode as nop.
module cu_decode
  import cu_pkg::*;
(
  input  logic [OPC_W-1:0]     opc,
  output cls_e                 cls,
  output logic [NUM_ALUOP-1:0] alu
);

  always_comb begin
    cls = C_NOP;
    alu = '0;
    case (opc)
      OP_LD:   cls = C_LD;
      OP_LDI:  cls = C_LDI;
      OP_ST:   cls = C_ST;
      OP_ADD:  begin cls = C_ALU; alu[A_ADD] = 1'b1; end
      OP_SUB:  begin cls = C_ALU; alu[A_SUB] = 1'b1; end
      OP_AND:  begin cls = C_ALU; alu[A_AND] = 1'b1; end
      OP_OR:   begin cls = C_ALU; alu[A_OR]  = 1'b1; end
      OP_SHR:  begin cls = C_ALU; alu[A_SHR] = 1'b1; end
      OP_SHL:  begin cls = C_ALU; alu[A_SHL] = 1'b1; end
      OP_ROR:  begin cls = C_ALU; alu[A_ROR] = 1'b1; end
      OP_ROL:  begin cls = C_ALU; alu[A_ROL] = 1'b1; end
      OP_ADDI: begin cls = C_IMM; alu[A_ADD] = 1'b1; end
      OP_ANDI: begin cls = C_IMM; alu[A_AND] = 1'b1; end
      OP_ORI:  begin cls = C_IMM; alu[A_OR]  = 1'b1; end
      OP_MUL:  begin cls = C_MULDIV; alu[A_MUL] = 1'b1; end
      OP_DIV:  begin cls = C_MULDIV; alu[A_DIV] = 1'b1; end
      OP_NEG:  begin cls = C_UNARY; alu[A_NEG] = 1'b1; end
      OP_NOT:  begin cls = C_UNARY; alu[A_NOT] = 1'b1; end
      OP_BR:   cls = C_BR;
      OP_JR:   cls = C_JR;
      OP_JAL:  cls = C_JAL;
      OP_IN:   cls = C_IN;
      OP_OUT:  cls = C_OUT;
      OP_MFHI: cls = C_MFHI;
      OP_MFLO: cls = C_MFLO;
      OP_HALT: cls = C_HALT;
      default: cls = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for the 32-bit bus datapath.
// CU_STEP_EN adds a step input that gates each instruction.
module control_sequencer
  import cu_pkg::*;
(
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 stop,
`ifdef CU_STEP_EN
  input  logic                 step,
`endif
  input  logic [31:0]          ir,
  input  logic                 con_ff,
  output logic                 run,
  output logic [NUM_DRV-1:0]   drv,
  output logic [NUM_LD-1:0]    ld,
  output logic [NUM_ALUOP-1:0] alu_op,
  output logic [2:0]           gr,
  output logic                 ba_out,
  output logic                 read,
  output logic                 write
);

  state_e state_q, state_d;
  cls_e   cls;
  logic   done;
  logic [NUM_ALUOP-1:0] alu_dec;
  logic   unused_ir;

  assign unused_ir = ^ir[26:0];

  cu_decode u_decode (
    .opc (ir[31:27]),
    .cls (cls),
    .alu (alu_dec)
  );

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2:  if (cls == C_NOP) done = 1'b1;
             else state_d = S_T3;
      S_T3:  case (cls)
               C_JR, C_IN, C_OUT,
               C_MFHI, C_MFLO: done = 1'b1;
               C_HALT:         state_d = S_HALT;
               default:        state_d = S_T4;
             endcase
      S_T4:  if (cls == C_UNARY || cls == C_JAL) done = 1'b1;
             else state_d = S_T5;
      S_T5:  if (cls == C_ALU || cls == C_IMM || cls == C_LDI)
               done = 1'b1;
             else state_d = S_T6;
      S_T6:  if (cls == C_MULDIV || cls == C_BR) done = 1'b1;
             else state_d = S_T7;
      S_T7:  done = 1'b1;
      S_HALT: state_d = S_HALT;
      S_WAIT: begin
`ifdef CU_STEP_EN
        if (stop)      state_d = S_HALT;
        else if (step) state_d = S_T0;
`else
        state_d = S_T0;
`endif
      end
      default: state_d = S_RST;
    endcase
    if (done) begin
`ifdef CU_STEP_EN
      state_d = stop ? S_HALT : S_WAIT;
`else
      state_d = stop ? S_HALT : S_T0;
`endif
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    run    = (state_q != S_HALT);
    drv    = '0;
    ld     = '0;
    alu_op = '0;
    gr     = '0;
    ba_out = 1'b0;
    read   = 1'b0;
    write  = 1'b0;
    unique case (state_q)
      S_T0: begin
        drv[D_PC] = 1'b1; ld[L_MAR] = 1'b1;
        alu_op[A_INCPC] = 1'b1; ld[L_Z] = 1'b1;
      end
      S_T1: begin
        drv[D_ZLO] = 1'b1; ld[L_PC] = 1'b1;
        read = 1'b1; ld[L_MDR] = 1'b1;
      end
      S_T2: begin
        drv[D_MDR] = 1'b1; ld[L_IR] = 1'b1;
      end
      S_T3: case (cls)
        C_ALU, C_IMM: begin
          gr[G_B] = 1'b1; drv[D_ROUT] = 1'b1; ld[L_Y] = 1'b1;
        end
        C_LD, C_LDI, C_ST: begin
          gr[G_B] = 1'b1; ba_out = 1'b1; ld[L_Y] = 1'b1;
        end
        C_MULDIV: begin
          gr[G_A] = 1'b1; drv[D_ROUT] = 1'b1; ld[L_Y] = 1'b1;
        end
        C_UNARY: begin
          gr[G_B] = 1'b1; drv[D_ROUT] = 1'b1;
          alu_op = alu_dec; ld[L_Z] = 1'b1;
        end
        C_BR: begin
          gr[G_A] = 1'b1; drv[D_ROUT] = 1'b1; ld[L_CON] = 1'b1;
        end
        C_JR: begin
          gr[G_A] = 1'b1; drv[D_ROUT] = 1'b1; ld[L_PC] = 1'b1;
        end
        C_JAL: begin
          drv[D_PC] = 1'b1; gr[G_B] = 1'b1; ld[L_R] = 1'b1;
        end
        C_IN: begin
          drv[D_INP] = 1'b1; gr[G_A] = 1'b1; ld[L_R] = 1'b1;
        end
        C_OUT: begin
          gr[G_A] = 1'b1; drv[D_ROUT] = 1'b1; ld[L_OUTP] = 1'b1;
        end
        C_MFHI: begin
          drv[D_HI] = 1'b1; gr[G_A] = 1'b1; ld[L_R] = 1'b1;
        end
        C_MFLO: begin
          drv[D_LO] = 1'b1; gr[G_A] = 1'b1; ld[L_R] = 1'b1;
        end
        default: ;
      endcase
      S_T4: case (cls)
        C_ALU: begin
          gr[G_C] = 1'b1; drv[D_ROUT] = 1'b1;
          alu_op = alu_dec; ld[L_Z] = 1'b1;
        end
        C_IMM: begin
          drv[D_C] = 1'b1; alu_op = alu_dec; ld[L_Z] = 1'b1;
        end
        C_LD, C_LDI, C_ST: begin
          drv[D_C] = 1'b1; alu_op[A_ADD] = 1'b1; ld[L_Z] = 1'b1;
        end
        C_MULDIV: begin
          gr[G_B] = 1'b1; drv[D_ROUT] = 1'b1;
          alu_op = alu_dec; ld[L_Z] = 1'b1;
        end
        C_UNARY: begin
          drv[D_ZLO] = 1'b1; gr[G_A] = 1'b1; ld[L_R] = 1'b1;
        end
        C_BR: begin
          drv[D_PC] = 1'b1; ld[L_Y] = 1'b1;
        end
        C_JAL: begin
          gr[G_A] = 1'b1; drv[D_ROUT] = 1'b1; ld[L_PC] = 1'b1;
        end
        default: ;
      endcase
      S_T5: case (cls)
        C_ALU, C_IMM, C_LDI: begin
          drv[D_ZLO] = 1'b1; gr[G_A] = 1'b1; ld[L_R] = 1'b1;
        end
        C_LD, C_ST: begin
          drv[D_ZLO] = 1'b1; ld[L_MAR] = 1'b1;
        end
        C_MULDIV: begin
          drv[D_ZLO] = 1'b1; ld[L_LO] = 1'b1;
        end
        C_BR: begin
          drv[D_C] = 1'b1; alu_op[A_ADD] = 1'b1; ld[L_Z] = 1'b1;
        end
        default: ;
      endcase
      S_T6: case (cls)
        C_LD: begin
          read = 1'b1; ld[L_MDR] = 1'b1;
        end
        C_ST: begin
          gr[G_A] = 1'b1; drv[D_ROUT] = 1'b1; ld[L_MDR] = 1'b1;
        end
        C_MULDIV: begin
          drv[D_ZHI] = 1'b1; ld[L_HI] = 1'b1;
        end
        C_BR: begin
          drv[D_ZLO] = con_ff; ld[L_PC] = con_ff;
        end
        default: ;
      endcase
      S_T7: case (cls)
        C_LD: begin
          drv[D_MDR] = 1'b1; gr[G_A] = 1'b1; ld[L_R] = 1'b1;
        end
        C_ST: write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

  a_drv_onehot: assert property (
    @(posedge clk) disable iff (clear) $onehot0(drv)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
// Expected vectors are built from hand-written control bit constants.
module tb_control_sequencer;

  localparam logic [8:0] COUT   = 9'h100;
  localparam logic [8:0] HIOUT  = 9'h080;
  localparam logic [8:0] ZHI    = 9'h020;
  localparam logic [8:0] ZLO    = 9'h010;
  localparam logic [8:0] PCOUT  = 9'h008;
  localparam logic [8:0] MDROUT = 9'h004;
  localparam logic [8:0] ROUT   = 9'h001;

  localparam logic [10:0] PCIN  = 11'h400;
  localparam logic [10:0] IRIN  = 11'h200;
  localparam logic [10:0] MARIN = 11'h100;
  localparam logic [10:0] YIN   = 11'h080;
  localparam logic [10:0] HIIN  = 11'h040;
  localparam logic [10:0] LOIN  = 11'h020;
  localparam logic [10:0] ZIN   = 11'h010;
  localparam logic [10:0] MDRIN = 11'h008;
  localparam logic [10:0] RIN   = 11'h004;
  localparam logic [10:0] CONIN = 11'h002;

  localparam logic [12:0] ADD   = 13'h0400;
  localparam logic [12:0] MUL   = 13'h0100;
  localparam logic [12:0] INCPC = 13'h0001;

  localparam logic [2:0] GA = 3'b100;
  localparam logic [2:0] GB = 3'b010;
  localparam logic [2:0] GC = 3'b001;

  localparam logic [31:0] ADD_I  = 32'h1988_8000;
  localparam logic [31:0] LD_I   = 32'h0080_0065;
  localparam logic [31:0] BR_I   = 32'h9000_0000;
  localparam logic [31:0] MUL_I  = 32'h7000_0000;
  localparam logic [31:0] JAL_I  = 32'hA000_0000;
  localparam logic [31:0] NOP_I  = 32'hC800_0000;
  localparam logic [31:0] UND_I  = 32'hF800_0000;
  localparam logic [31:0] HALT_I = 32'hD000_0000;

  logic        clk, clear, stop, con_ff;
  logic        step;
  logic [31:0] ir;
  logic        run, ba_out, rd, wr;
  logic [8:0]  drv;
  logic [10:0] ld;
  logic [12:0] alu_op;
  logic [2:0]  gr;
  logic [39:0] obs;
  int          total = 0;
  int          bad = 0;

  control_sequencer dut (
    .clk    (clk),
    .clear  (clear),
    .stop   (stop),
`ifdef CU_STEP_EN
    .step   (step),
`endif
    .ir     (ir),
    .con_ff (con_ff),
    .run    (run),
    .drv    (drv),
    .ld     (ld),
    .alu_op (alu_op),
    .gr     (gr),
    .ba_out (ba_out),
    .read   (rd),
    .write  (wr)
  );

  assign obs = {run, drv, ld, alu_op, gr, ba_out, rd, wr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] v(
    input logic r, input logic [8:0] d, input logic [10:0] l,
    input logic [12:0] a, input logic [2:0] g,
    input logic b, input logic rr, input logic ww);
    return {r, d, l, a, g, b, rr, ww};
  endfunction

  localparam logic [39:0] IDLE = {1'b1, 39'd0};
  localparam logic [39:0] HLT  = 40'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // checks T0..T2 starting in T0, leaves the bench in T2
  task automatic fetch(input string t);
    chk({t, "-T0"}, v(1, PCOUT, MARIN | ZIN, INCPC, 0, 0, 0, 0));
    tick();
    chk({t, "-T1"}, v(1, ZLO, PCIN | MDRIN, 0, 0, 0, 1, 0));
    tick();
    chk({t, "-T2"}, v(1, MDROUT, IRIN, 0, 0, 0, 0, 0));
  endtask

  task automatic nxt();
`ifdef CU_STEP_EN
    tick();
    chk("wait", IDLE);
    step = 1'b1;
    tick();
    step = 1'b0;
`else
    tick();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1; stop = 1'b0; con_ff = 1'b0;
    step = 1'b0; ir = ADD_I;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", IDLE);
    clear = 1'b0;
    tick();

    fetch("add"); tick();
    chk("add-T3", v(1, ROUT, YIN, 0, GB, 0, 0, 0)); tick();
    chk("add-T4", v(1, ROUT, ZIN, ADD, GC, 0, 0, 0)); tick();
    chk("add-T5", v(1, ZLO, RIN, 0, GA, 0, 0, 0)); nxt();

    fetch("add2"); tick(); tick();
    clear = 1'b1;
    #2;
    chk("clr-mid-T4", IDLE);
    #2;
    clear = 1'b0;
    tick();

    ir = LD_I;
    fetch("ld"); tick();
    chk("ld-T3", v(1, 0, YIN, 0, GB, 1, 0, 0)); tick();
    chk("ld-T4", v(1, COUT, ZIN, ADD, 0, 0, 0, 0)); tick();
    chk("ld-T5", v(1, ZLO, MARIN, 0, 0, 0, 0, 0)); tick();
    chk("ld-T6", v(1, 0, MDRIN, 0, 0, 0, 1, 0)); tick();
    chk("ld-T7", v(1, MDROUT, RIN, 0, GA, 0, 0, 0)); nxt();

    for (int c = 0; c < 2; c++) begin
      ir = BR_I;
      con_ff = c[0];
      fetch("br"); tick();
      chk("br-T3", v(1, ROUT, CONIN, 0, GA, 0, 0, 0)); tick();
      chk("br-T4", v(1, PCOUT, YIN, 0, 0, 0, 0, 0)); tick();
      chk("br-T5", v(1, COUT, ZIN, ADD, 0, 0, 0, 0)); tick();
      if (c == 0) chk("br-T6-nt", IDLE);
      else chk("br-T6-tk", v(1, ZLO, PCIN, 0, 0, 0, 0, 0));
      nxt();
    end
    con_ff = 1'b0;

    ir = MUL_I;
    fetch("mul"); tick();
    chk("mul-T3", v(1, ROUT, YIN, 0, GA, 0, 0, 0)); tick();
    chk("mul-T4", v(1, ROUT, ZIN, MUL, GB, 0, 0, 0)); tick();
    chk("mul-T5", v(1, ZLO, LOIN, 0, 0, 0, 0, 0)); tick();
    chk("mul-T6", v(1, ZHI, HIIN, 0, 0, 0, 0, 0)); nxt();

    ir = JAL_I;
    fetch("jal"); tick();
    chk("jal-T3", v(1, PCOUT, RIN, 0, GB, 0, 0, 0)); tick();
    chk("jal-T4", v(1, ROUT, PCIN, 0, GA, 0, 0, 0)); nxt();

    ir = NOP_I;
    fetch("nop"); nxt();
    ir = UND_I;
    fetch("undef"); nxt();

    ir = ADD_I;
    stop = 1'b1;
    fetch("stop"); tick(); tick(); tick();
    chk("stop-T5", v(1, ZLO, RIN, 0, GA, 0, 0, 0)); tick();
    chk("stop-halt", HLT);
    stop = 1'b0;
    tick();
    chk("stop-halt-hold", HLT);

    clear = 1'b1;
    #2;
    chk("clr-from-halt", IDLE);
    #2;
    clear = 1'b0;
    tick();

    ir = HALT_I;
    fetch("halt"); tick();
    chk("halt-T3", IDLE); tick();
    for (int i = 0; i < 20; i++) begin
      chk("halt-hold", HLT);
      tick();
    end

`ifdef CU_STEP_EN
    clear = 1'b1;
    #2;
    clear = 1'b0;
    tick();
    ir = NOP_I;
    fetch("step1"); tick();
    chk("step-wait1", IDLE);
    step = 1'b1;
    tick();
    step = 1'b0;
    fetch("step2"); tick();
    chk("step-wait2", IDLE);
    tick(); tick();
    chk("step-wait3", IDLE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
